neuron_state_ram: RTL and testbench
===================================

Name: neuron_state_ram

Overview:
Parametrised multi-read-port neuron state memory. Successor to the single-read, combinational-read neuron RAM.
- Registered reads: 1-cycle latency, per-port valid.
- Write-first forwarding.
- Accumulate write mode with signed saturation, for neuron membrane/weight updates.
- Hardware clear engine that sweeps all locations to INIT_VALUE after reset or on request.
- Sits between the layer sequencer (writes/accumulates) and the activation pipelines (reads).

Parameters:
DATA_WIDTH, 8, bits per word, two's-complement signed in accumulate mode
ADDR_WIDTH, 16, address bus width
DEPTH, 2**ADDR_WIDTH, implemented locations (DEPTH <= 2**ADDR_WIDTH)
NUM_RD_PORTS, 2, independent read ports (1..8)
INIT_VALUE, 0, word written to every location by the clear engine

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
clear_req  in  1  pulse: start clear sweep (honoured only in IDLE)
busy  out  1  1 while the clear sweep runs
wr_en  in  1  write request
wr_mode  in  1  0 = overwrite, 1 = accumulate (mem += wr_data, saturating)
wr_addr  in  ADDR_WIDTH  write address
wr_data  in  DATA_WIDTH  write operand
acc_sat  out  1  registered pulse: last accumulate saturated
rd_en  in  NUM_RD_PORTS  per-port read request
rd_addr  in  NUM_RD_PORTS*ADDR_WIDTH  port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
rd_data  out  NUM_RD_PORTS*DATA_WIDTH  port p at [p*DATA_WIDTH +: DATA_WIDTH]
rd_valid  out  NUM_RD_PORTS  per-port data valid, 1 cycle after rd_en

Behaviour:
- Reset values: busy=1, acc_sat=0, rd_valid=0, rd_data=0, clear pointer=0, FSM=CLEAR. Memory contents are not reset directly; the sweep overwrites them.
- FSM states:
  - CLEAR: each cycle mem[ptr] <= INIT_VALUE, then ptr++. When ptr==DEPTH-1 is written, go to IDLE the next cycle. Sweep takes exactly DEPTH cycles; busy deasserts on the following edge.
  - IDLE: busy=0, user ports active. clear_req=1 -> ptr=0, busy=1, go to CLEAR.
- During CLEAR:
  - wr_en and rd_en are ignored; no memory change from user ports.
  - rd_valid=0 and acc_sat=0.
  - clear_req is ignored.
- rst mid-sweep: restarts the sweep from address 0.
- Write, overwrite mode: mem[wr_addr] <= wr_data at the edge.
- Write, accumulate mode:
  - sum = mem[wr_addr] + wr_data, computed at DATA_WIDTH+1 bits signed.
  - If sum > 2^(DATA_WIDTH-1)-1, store max positive and set acc_sat=1 next cycle.
  - If sum < -2^(DATA_WIDTH-1), store min negative and set acc_sat=1.
  - Otherwise store sum; acc_sat=0.
  - acc_sat is 0 in any cycle without an accumulate write.
- Out-of-range address (>= DEPTH): write is dropped, acc_sat=0. Read returns 0 with rd_valid=1.
- Read:
  - rd_en[p] at edge k -> rd_data[p] and rd_valid[p]=1 after edge k+1.
  - rd_data holds its last value when rd_en=0; rd_valid=0.
- Write-first forwarding: if wr_en and rd_addr[p]==wr_addr in the same cycle, the port returns the value being written. For accumulate writes this is the saturated sum. Applies independently to every port.
- All ports may read the same address in the same cycle; each gets identical data.
- Back-to-back accumulates to one address on consecutive cycles must chain. The second add uses the first result, with no lost update.
- rd_data is never high-Z; there is no output-enable.

Test Plan:
- Reset sweep (DEPTH=16, INIT_VALUE=8'h05): rst 1 cycle -> busy=1 for exactly 16 cycles, then 0. Reads of addr 0..15 on both ports return 8'h05 with rd_valid 1 cycle after rd_en.
- Overwrite + forwarding: wr addr 3 = 8'h2A while port0 reads addr 3 and port1 reads addr 4 -> next cycle port0=8'h2A, port1=old mem[4]. Re-read addr 3 returns 8'h2A.
- Accumulate saturation: mem[7]=8'd120. Accumulate +10 -> mem[7]=8'd127, acc_sat=1 for one cycle. mem[8]=-8'd120, accumulate -20 -> mem[8]=-8'd128 (8'h80), acc_sat=1. Accumulate +3 to mem[9]=8'd4 -> 8'd7, acc_sat=0.
- Chained accumulate: mem[2]=0. Accumulate +1 on 5 consecutive cycles with port1 reading addr 2 each cycle -> port1 returns 1,2,3,4,5, and final mem[2]=5.
- clear_req mid-operation: write 8'hFF to addr 1, pulse clear_req. wr_en/rd_en are asserted during the sweep and must have no effect, with rd_valid=0. After busy falls, addr 1 reads INIT_VALUE. Asserting rst at sweep cycle 6 restarts the full 16-cycle sweep.
- Out-of-range (DEPTH=12, ADDR_WIDTH=4): write 8'h33 to addr 13 -> no location changes. Read addr 13 -> rd_data=0, rd_valid=1.

Source files
------------

// File: rtl/neuron_state_ram_if.sv
// Bus between the layer sequencer (master) and the neuron state RAM (slave):
// clear control, write/accumulate channel and the bank of read ports.
interface neuron_state_ram_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 16,
    parameter int NUM_RD_PORTS = 2
);
    logic                                 clear_req;
    logic                                 busy;
    logic                                 wr_en;
    logic                                 wr_mode;
    logic [ADDR_WIDTH-1:0]                wr_addr;
    logic [DATA_WIDTH-1:0]                wr_data;
    logic                                 acc_sat;
    logic [NUM_RD_PORTS-1:0]              rd_en;
    logic [NUM_RD_PORTS*ADDR_WIDTH-1:0]   rd_addr;
    logic [NUM_RD_PORTS*DATA_WIDTH-1:0]   rd_data;
    logic [NUM_RD_PORTS-1:0]              rd_valid;

    modport master (
        output clear_req, wr_en, wr_mode, wr_addr, wr_data, rd_en, rd_addr,
        input  busy, acc_sat, rd_data, rd_valid
    );

    modport slave (
        input  clear_req, wr_en, wr_mode, wr_addr, wr_data, rd_en, rd_addr,
        output busy, acc_sat, rd_data, rd_valid
    );
endinterface

// File: rtl/neuron_state_ram.sv
// Multi-read-port neuron state memory: registered reads, write-first forwarding,
// saturating accumulate writes and a sweep engine that clears every location.
//
// state    | meaning
// ST_CLEAR | sweep writes INIT_VALUE to mem[ptr], user ports ignored, busy=1
// ST_IDLE  | user writes/accumulates and reads active, clear_req accepted
module neuron_state_ram #(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DEPTH        = 2**ADDR_WIDTH,
    parameter int                    NUM_RD_PORTS = 2,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    neuron_state_ram_if.slave    bus
);
    localparam int                       IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]      DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(DEPTH-1);
    localparam logic [DATA_WIDTH-1:0]    MAX_POS  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0]    MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t                             state_q, state_d;
    logic [IDX_W-1:0]                   ptr_q, ptr_d;
    logic                               busy_q, busy_d;
    logic                               acc_sat_q, acc_sat_d;
    logic [NUM_RD_PORTS-1:0]            rd_valid_q, rd_valid_d;
    logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic [DATA_WIDTH-1:0]              mem [DEPTH];

    logic                               idle;
    logic                               wr_ok;
    logic [IDX_W-1:0]                   wr_idx;
    logic [DATA_WIDTH-1:0]              wr_old;
    logic [DATA_WIDTH:0]                sum;
    logic                               sat_hi, sat_lo;
    logic [DATA_WIDTH-1:0]              wr_value;
    logic [DATA_WIDTH-1:0]              rd_word [NUM_RD_PORTS];

    always_comb begin
        idle   = (state_q == ST_IDLE);
        wr_idx = bus.wr_addr[IDX_W-1:0];
        wr_ok  = idle && bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_W);
        wr_old = mem[wr_idx];
        // One extra bit of headroom: overflow shows up as the top two bits disagreeing.
        sum    = {wr_old[DATA_WIDTH-1], wr_old} + {bus.wr_data[DATA_WIDTH-1], bus.wr_data};
        sat_hi = ~sum[DATA_WIDTH] &  sum[DATA_WIDTH-1];
        sat_lo =  sum[DATA_WIDTH] & ~sum[DATA_WIDTH-1];
        if (!bus.wr_mode)  wr_value = bus.wr_data;
        else if (sat_hi)   wr_value = MAX_POS;
        else if (sat_lo)   wr_value = MIN_NEG;
        else               wr_value = sum[DATA_WIDTH-1:0];
    end

    always_comb begin
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            rd_word[p] = '0;
            if (wr_ok && (bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == bus.wr_addr))
                rd_word[p] = wr_value;
            else if ({1'b0, bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]} < DEPTH_W)
                rd_word[p] = mem[bus.rd_addr[p*ADDR_WIDTH +: IDX_W]];
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rd_valid_d = '0;
        rd_data_d  = rd_data_q;
        case (state_q)
            ST_CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end
            end
            default: begin
                if (bus.clear_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
        endcase
        busy_d    = (state_d == ST_CLEAR);
        acc_sat_d = wr_ok && bus.wr_mode && (sat_hi || sat_lo);
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            rd_valid_d[p] = idle && bus.rd_en[p];
            if (rd_valid_d[p])
                rd_data_d[p*DATA_WIDTH +: DATA_WIDTH] = rd_word[p];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            ptr_q      <= '0;
            busy_q     <= 1'b1;
            acc_sat_q  <= 1'b0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            acc_sat_q  <= acc_sat_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Storage has no reset; the sweep that follows reset initialises it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_CLEAR)
                mem[ptr_q] <= INIT_VALUE;
            else if (wr_ok)
                mem[wr_idx] <= wr_value;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.acc_sat  = acc_sat_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
endmodule

// File: tb/tb_neuron_state_ram.sv
// Directed bench: a DEPTH=16 instance for sweep/write/accumulate/clear behaviour
// and a DEPTH=12 instance for out-of-range accesses.
module tb_neuron_state_ram;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   n;
    int   bad;

    always #5 clk = ~clk;

    neuron_state_ram_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_RD_PORTS(2)) ia ();
    neuron_state_ram_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_RD_PORTS(2)) ib ();

    neuron_state_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16), .NUM_RD_PORTS(2),
                       .INIT_VALUE(8'h05)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    neuron_state_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12), .NUM_RD_PORTS(2),
                       .INIT_VALUE(8'h00)) dut_b (.clk(clk), .rst(rst), .bus(ib));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        ia.clear_req = 1'b0; ia.wr_en = 1'b0; ia.wr_mode = 1'b0;
        ia.wr_addr = '0; ia.wr_data = '0; ia.rd_en = '0; ia.rd_addr = '0;
    endtask

    task automatic idle_b();
        ib.clear_req = 1'b0; ib.wr_en = 1'b0; ib.wr_mode = 1'b0;
        ib.wr_addr = '0; ib.wr_data = '0; ib.rd_en = '0; ib.rd_addr = '0;
    endtask

    task automatic wr_a(input logic [3:0] a, input logic [7:0] d, input logic mode);
        ia.wr_en = 1'b1; ia.wr_addr = a; ia.wr_data = d; ia.wr_mode = mode;
    endtask

    task automatic rd_a(input logic [1:0] en, input logic [3:0] a0, input logic [3:0] a1);
        ia.rd_en = en; ia.rd_addr = {a1, a0};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_a();
        idle_b();
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(ia.busy), 32'd1);
        chk("rst_acc_sat", 32'(ia.acc_sat), 32'd0);
        chk("rst_rd_valid", 32'(ia.rd_valid), 32'd0);
        chk("rst_rd_data", 32'(ia.rd_data), 32'd0);

        n = 0;
        while (ia.busy && n < 40) begin tick(); n++; end
        chk("reset_sweep_len", n, 16);

        for (int a = 0; a < 16; a++) begin
            rd_a(2'b11, 4'(a), 4'(15 - a));
            tick();
            chk("init_read", {14'd0, ia.rd_valid, ia.rd_data}, {14'd0, 2'b11, 16'h0505});
        end
        idle_a();
        tick();
        chk("hold_valid", 32'(ia.rd_valid), 32'd0);
        chk("hold_data", 32'(ia.rd_data), 32'h0505);

        // overwrite with write-first forwarding on port0, plain read on port1
        wr_a(4'd4, 8'h44, 1'b0);
        tick();
        idle_a();
        wr_a(4'd3, 8'h2A, 1'b0);
        rd_a(2'b11, 4'd3, 4'd4);
        tick();
        chk("fwd_data", 32'(ia.rd_data), 32'h442A);
        chk("fwd_valid", 32'(ia.rd_valid), 32'd3);
        idle_a();
        rd_a(2'b01, 4'd3, 4'd0);
        tick();
        chk("reread3", 32'(ia.rd_data), 32'h442A);

        // accumulate saturation
        idle_a(); wr_a(4'd7, 8'd120, 1'b0); tick();
        wr_a(4'd8, 8'h88, 1'b0); tick();
        wr_a(4'd9, 8'd4, 1'b0); tick();
        wr_a(4'd7, 8'd10, 1'b1); tick();
        chk("sat_pos_flag", 32'(ia.acc_sat), 32'd1);
        wr_a(4'd8, 8'hEC, 1'b1); tick();
        chk("sat_neg_flag", 32'(ia.acc_sat), 32'd1);
        wr_a(4'd9, 8'd3, 1'b1); tick();
        chk("nosat_flag", 32'(ia.acc_sat), 32'd0);
        idle_a();
        rd_a(2'b11, 4'd7, 4'd8);
        tick();
        chk("sat_values", 32'(ia.rd_data), 32'h807F);
        rd_a(2'b01, 4'd9, 4'd0);
        tick();
        chk("nosat_value", 32'(ia.rd_data), 32'h8007);

        // chained accumulates observed through port1 forwarding
        idle_a(); wr_a(4'd2, 8'd0, 1'b0); tick();
        for (int i = 1; i <= 5; i++) begin
            wr_a(4'd2, 8'd1, 1'b1);
            rd_a(2'b10, 4'd0, 4'd2);
            tick();
            chk("chain", 32'(ia.rd_data[15:8]), 32'(i));
        end
        idle_a();
        rd_a(2'b01, 4'd2, 4'd0);
        tick();
        chk("chain_final", 32'(ia.rd_data[7:0]), 32'd5);

        // clear_req mid-operation with user traffic during the sweep
        idle_a(); wr_a(4'd1, 8'hFF, 1'b0); tick();
        idle_a(); ia.clear_req = 1'b1; tick();
        chk("clear_busy", 32'(ia.busy), 32'd1);
        n = 0; bad = 0;
        while (ia.busy && n < 40) begin
            wr_a(4'd1, 8'h77, 1'b0);
            rd_a(2'b11, 4'd1, 4'd3);
            ia.clear_req = (n == 3);
            tick();
            n++;
            if (ia.rd_valid !== 2'b00 || ia.acc_sat !== 1'b0) bad++;
        end
        chk("clear_sweep_len", n, 16);
        chk("clear_quiet_outputs", bad, 0);
        idle_a();
        rd_a(2'b11, 4'd1, 4'd3);
        tick();
        chk("clear_read", {14'd0, ia.rd_valid, ia.rd_data}, {14'd0, 2'b11, 16'h0505});

        // reset at sweep cycle 6 restarts a full sweep
        idle_a(); ia.clear_req = 1'b1; tick();
        ia.clear_req = 1'b0;
        repeat (6) tick();
        chk("mid_sweep_busy", 32'(ia.busy), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_mid_busy", 32'(ia.busy), 32'd1);
        n = 0;
        while (ia.busy && n < 40) begin tick(); n++; end
        chk("rst_mid_sweep_len", n, 16);

        // out-of-range on the DEPTH=12 instance
        chk("b_idle", 32'(ib.busy), 32'd0);
        ib.wr_en = 1'b1; ib.wr_mode = 1'b0; ib.wr_addr = 4'd13; ib.wr_data = 8'h33;
        ib.rd_en = 2'b11; ib.rd_addr = {4'd11, 4'd13};
        tick();
        chk("oor_fwd_data", 32'(ib.rd_data), 32'h0000);
        chk("oor_valid", 32'(ib.rd_valid), 32'd3);
        chk("oor_acc_sat", 32'(ib.acc_sat), 32'd0);
        idle_b();
        ib.rd_en = 2'b11; ib.rd_addr = {4'd1, 4'd13};
        tick();
        chk("oor_read", {14'd0, ib.rd_valid, ib.rd_data}, {14'd0, 2'b11, 16'h0000});
        ib.rd_addr = {4'd5, 4'd11};
        tick();
        chk("oor_no_change", 32'(ib.rd_data), 32'h0000);
        idle_b();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
